// File: rtl/mips_mem_resp.sv
// mips_mem_resp: single-outstanding data-memory responder for a MIPS MEM stage.
// Request/response valid-ready handshakes, fixed LATENCY from acceptance to
// rsp_valid, word-addressed memory of DEPTH 32-bit words (not reset).
// Optional feature macro: MIPS_MEM_ERR_CHECK_EN enables misaligned/out-of-range
// fault detection (rsp_err=1, rdata=0, write suppressed); when undefined the
// address is wrapped modulo DEPTH words and rsp_err is tied 0.
module mips_mem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned HI_SH = IDX_W + 2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic [31:0]      r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx_raw;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_accept;
  logic             w_rsp_done;

  // Word index from the byte address, folded into the memory range
  assign w_idx_raw = req_addr[IDX_W+1:2];
  assign w_idx     = IDX_W'(32'(w_idx_raw) % DEPTH);

`ifdef MIPS_MEM_ERR_CHECK_EN
  logic w_misaligned;
  logic w_out_of_range;

  // Fault when misaligned, index past the array, or any upper address bit set
  assign w_misaligned   = (req_addr[1:0] != 2'b00);
  assign w_out_of_range = (32'(w_idx_raw) >= DEPTH) ||
                          ((req_addr >> HI_SH) != 32'd0);
  assign w_err          = w_misaligned | w_out_of_range;
`else
  logic w_unused_addr;

  // Low byte-offset bits and upper address bits are deliberately ignored
  assign w_unused_addr = ^{req_addr[1:0], (req_addr >> HI_SH)};
  assign w_err         = 1'b0;
`endif

  assign w_accept   = rst_n && (r_state == IDLE) && req_valid;
  assign w_rsp_done = (r_state == RESP) && rsp_ready;

  // State and latency counter registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY <= 1) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        // Leave BUSY on the edge where the count would reach zero
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered handshake outputs and response payload captured at acceptance
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= (!req_we && !w_err) ? r_mem[w_idx] : 32'd0;
      end else if (w_rsp_done) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Store commits at the acceptance edge; contents survive reset
  always_ff @(posedge clk1) begin
    if (w_accept && req_we && !w_err) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
`ifdef MIPS_MEM_ERR_CHECK_EN
  assign rsp_err   = r_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_resp.sv
// Directed bench for mips_mem_resp (DEPTH=1024, LATENCY=2); expectations
// follow MIPS_MEM_ERR_CHECK_EN when it is defined, wrap behaviour otherwise.
module tb_mips_mem_resp;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_err = 0;
  int n_chk = 0;

`ifdef MIPS_MEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk1 = ~clk1;

  mips_mem_resp #(
    .DEPTH  (1024),
    .LATENCY(2)
  ) u_dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request/response with rsp_ready held high
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int  k;
    bit  ok;
    @(negedge clk1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b1;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 20) begin
      if (req_ready) ok = 1'b1;
      else begin
        @(negedge clk1);
        k++;
      end
    end
    if (!ok) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk1);
      if (rsp_valid) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    if (!ok) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] exp_w4;
    int          acc_cyc [4];
    int          n_acc;
    int          cyc;
    bit          ok;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Known contents for word 0
    xact(1'b1, 32'h0, 32'h0BADF00D, rd, er, lat);
    check("st0_err", 32'(er), 32'd0);

    // Store then load 0x10
    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("st10_rdata", rd, 32'd0);
    check("st10_err", 32'(er), 32'd0);
    check("st10_lat", 32'(lat), 32'd2);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_lat", 32'(lat), 32'd2);

    // Misaligned store to 0x13 (wraps onto word 4 when unchecked)
    xact(1'b1, 32'h13, 32'hFFFF0000, rd, er, lat);
    check("st13_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check("st13_rdata", rd, 32'd0);
    check("st13_lat", 32'(lat), 32'd2);
    exp_w4 = ERR_EN ? 32'hDEADBEEF : 32'hFFFF0000;
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10b_rdata", rd, exp_w4);

    // Out-of-range store to 0x1000, then load word 0
    xact(1'b1, 32'h1000, 32'h00001234, rd, er, lat);
    check("st1000_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check("st1000_rdata", rd, 32'd0);
    xact(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("ld0_rdata", rd, ERR_EN ? 32'h0BADF00D : 32'h00001234);
    check("ld0_err", 32'(er), 32'd0);

    // Misaligned load returns zero data when checked
    xact(1'b0, 32'h11, 32'h0, rd, er, lat);
    check("ld11_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check("ld11_rdata", rd, ERR_EN ? 32'd0 : exp_w4);

    // High address bit set
    xact(1'b0, 32'h8000_0010, 32'h0, rd, er, lat);
    check("ldhi_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check("ldhi_rdata", rd, ERR_EN ? 32'd0 : exp_w4);

    // Response back-pressure: rsp_ready low for 5 cycles
    @(negedge clk1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    rsp_ready = 1'b0;
    check("bp_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk1);
      if (rsp_valid) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    check("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, exp_w4);
      check("bp_hold_req_ready", 32'(req_ready), 32'd0);
      if (i < 4) @(negedge clk1);
    end
    rsp_ready = 1'b1;
    @(negedge clk1);
    check("bp_after_req_ready", 32'(req_ready), 32'd1);
    check("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset one cycle after an accepted store; store must persist
    @(negedge clk1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    rsp_ready = 1'b1;
    check("rs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(posedge clk1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rs_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    check("rs_req_ready_rel", 32'(req_ready), 32'd1);
    check("rs_rsp_valid_rel", 32'(rsp_valid), 32'd0);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("rs_ld20_rdata", rd, 32'hA5A5A5A5);
    check("rs_ld20_lat", 32'(lat), 32'd2);

    // Back-to-back with req_valid and rsp_ready held high
    @(negedge clk1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    rsp_ready = 1'b1;
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 4 && cyc < 40) begin
      cyc++;
      if (req_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (n_acc < 4) @(negedge clk1);
    end
    check("b2b_count", 32'(n_acc), 32'd4);
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (i < n_acc) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk1);
      if (rsp_valid) ok = 1'b1;
    end
    check("b2b_last_rdata", rsp_rdata, exp_w4);
    @(negedge clk1);
    check("b2b_drain_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
